// File: rtl/pulse_interval_monitor.sv
// Measures clock-cycle intervals between rising edges of pulse_in, queues them in a
// valid/ready FIFO and tracks sat/drop flags. Define PIM_STATS_EN to build the statistics.
module pulse_interval_monitor #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [CNT_W-1:0] iv_data,
    output logic             iv_valid,
    input  logic             iv_ready,
    output logic [15:0]      pulse_count,
    output logic [CNT_W-1:0] min_iv,
    output logic [CNT_W-1:0] max_iv,
    output logic             sat,
    output logic             drop
);
    localparam int unsigned      AW        = $clog2(DEPTH);
    localparam int unsigned      CW        = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CW-1:0]    FIFO_FULL = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_MEASURE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pulse_q;
    logic             r_sat;
    logic             r_drop;
    logic             w_clr;
    logic             w_edge;
    logic             w_push;
    logic             w_sat_set;

    logic [CNT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic [CNT_W-1:0] r_iv_data;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic             w_drop_set;
    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [CNT_W-1:0] w_head_nxt;

    assign w_clr  = rst | clear;
    assign w_edge = pulse_in & ~r_pulse_q & ena;

    // Measurement FSM: next state, counter and push strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_sat_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_edge) begin
                    w_push    = 1'b1;
                    w_cnt_nxt = CNT_W'(1);
                end else if (ena && (r_cnt != CNT_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_sat_set = (w_cnt_nxt == CNT_MAX);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO control; a push into a full FIFO survives only if the head pops the same cycle
    always_comb begin
        w_pop       = r_valid & iv_ready;
        w_full      = (r_count == FIFO_FULL);
        w_wr_en     = w_push & (~w_full | w_pop);
        w_drop_set  = w_push & w_full & ~w_pop;
        w_rd_nxt    = r_rd_ptr + AW'(w_pop);
        w_count_nxt = r_count - CW'(w_pop) + CW'(w_wr_en);
        w_head_nxt  = (w_wr_en && (r_count == CW'(w_pop))) ? r_cnt : r_mem[w_rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pulse_q <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_iv_data <= '0;
            r_sat     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pulse_q <= pulse_in;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr  <= w_rd_nxt;
            r_count   <= w_count_nxt;
            r_valid   <= (w_count_nxt != '0);
            r_iv_data <= w_head_nxt;
            r_sat     <= r_sat | w_sat_set;
            r_drop    <= r_drop | w_drop_set;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !w_clr) begin
            r_mem[r_wr_ptr] <= r_cnt;
        end
    end

    assign iv_data  = r_iv_data;
    assign iv_valid = r_valid;
    assign sat      = r_sat;
    assign drop     = r_drop;

`ifdef PIM_STATS_EN
    logic [15:0]      r_pulse_count;
    logic [CNT_W-1:0] r_min_iv;
    logic [CNT_W-1:0] r_max_iv;

    // Running statistics; dropped intervals still count toward min/max
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_pulse_count <= '0;
            r_min_iv      <= CNT_MAX;
            r_max_iv      <= '0;
        end else begin
            if (w_edge && (r_pulse_count != 16'hFFFF)) begin
                r_pulse_count <= r_pulse_count + 16'd1;
            end
            if (w_push) begin
                if (r_cnt < r_min_iv) begin
                    r_min_iv <= r_cnt;
                end
                if (r_cnt > r_max_iv) begin
                    r_max_iv <= r_cnt;
                end
            end
        end
    end

    assign pulse_count = r_pulse_count;
    assign min_iv      = r_min_iv;
    assign max_iv      = r_max_iv;
`else
    assign pulse_count = '0;
    assign min_iv      = '0;
    assign max_iv      = '0;
`endif

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Scoreboard bench for pulse_interval_monitor: a 16-bit and a 4-bit counter instance share
// stimulus; expected intervals are queued per instance and checked as the DUTs present them.
module tb_pulse_interval_monitor;
    localparam int unsigned CW   = 16;
    localparam int unsigned CW_S = 4;
`ifdef PIM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ena, pulse_in, clear, iv_ready;

    logic [CW-1:0]   iv_data, min_iv, max_iv;
    logic            iv_valid, sat, drop;
    logic [15:0]     pulse_count;
    logic [CW_S-1:0] s_iv_data, s_min_iv, s_max_iv;
    logic            s_iv_valid, s_sat, s_drop;
    logic [15:0]     s_pulse_count;

    pulse_interval_monitor #(.CNT_W(CW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in), .clear(clear),
        .iv_data(iv_data), .iv_valid(iv_valid), .iv_ready(iv_ready),
        .pulse_count(pulse_count), .min_iv(min_iv), .max_iv(max_iv),
        .sat(sat), .drop(drop)
    );

    pulse_interval_monitor #(.CNT_W(CW_S), .DEPTH(4)) dut_s (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in), .clear(clear),
        .iv_data(s_iv_data), .iv_valid(s_iv_valid), .iv_ready(iv_ready),
        .pulse_count(s_pulse_count), .min_iv(s_min_iv), .max_iv(s_max_iv),
        .sat(s_sat), .drop(s_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int q16[$];
    int q4[$];
    int pops16 = 0;
    int pops4  = 0;
    logic [63:0] pv;
    logic [63:0] ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    // Monitors: pop expected value whenever a DUT transfer happens
    always @(negedge clk) begin
        if (!rst && iv_valid && iv_ready) begin
            pops16++;
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop16_extra: got %0d required no transfer", iv_data);
            end else begin
                chk("pop16", 32'(iv_data), 32'(q16.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_iv_valid && iv_ready) begin
            pops4++;
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop4_extra: got %0d required no transfer", s_iv_data);
            end else begin
                chk("pop4", 32'(s_iv_data), 32'(q4.pop_front()));
            end
        end
    end

    task automatic play(input int len);
        for (int c = 0; c < len; c++) begin
            pulse_in = pv[c];
            ena      = ev[c];
            @(posedge clk);
            #1;
        end
        pulse_in = 1'b0;
        ena      = 1'b1;
    endtask

    task automatic do_clear();
        iv_ready = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic push_both(input int v16, input int v4);
        q16.push_back(v16);
        q4.push_back(v4);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; pulse_in = 1'b0; clear = 1'b0; iv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(iv_valid), 0);
        chk("rst_count", 32'(pulse_count), 0);
        chk("rst_min", 32'(min_iv), st(32'hFFFF));
        chk("rst_max", 32'(max_iv), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_min_s", 32'(s_min_iv), st(32'hF));

        // Interval values: pulses at 10, 15, 22
        iv_ready = 1'b1;
        pv = '0; pv[10] = 1'b1; pv[15] = 1'b1; pv[22] = 1'b1;
        ev = '1;
        push_both(5, 5);
        push_both(7, 7);
        play(30);
        chk("iv_drain", 32'(q16.size() + q4.size()), 0);
        chk("iv_count", 32'(pulse_count), st(3));
        chk("iv_min", 32'(min_iv), st(5));
        chk("iv_max", 32'(max_iv), st(7));
        chk("iv_empty", 32'(iv_valid), 0);
        do_clear();

        // Enable gating: ena low 13..15, pulse at 14 lost
        iv_ready = 1'b1;
        pv = '0; pv[10] = 1'b1; pv[14] = 1'b1; pv[20] = 1'b1;
        ev = '1; ev[13] = 1'b0; ev[14] = 1'b0; ev[15] = 1'b0;
        push_both(7, 7);
        play(28);
        chk("gate_drain", 32'(q16.size() + q4.size()), 0);
        chk("gate_count", 32'(pulse_count), st(2));
        do_clear();

        // FIFO overflow: 6 pulses 4 apart, no consumer
        pv = '0;
        for (int i = 0; i < 6; i++) pv[2 + 4 * i] = 1'b1;
        ev = '1;
        for (int i = 0; i < 4; i++) push_both(4, 4);
        play(26);
        chk("ovf_valid", 32'(iv_valid), 1);
        chk("ovf_data", 32'(iv_data), 4);
        chk("ovf_drop", 32'(drop), 1);
        chk("ovf_drop_s", 32'(s_drop), 1);
        chk("ovf_sat", 32'(sat), 0);
        chk("ovf_count", 32'(pulse_count), st(6));
        chk("ovf_max", 32'(max_iv), st(4));
        pops16 = 0;
        pops4  = 0;
        iv_ready = 1'b1;
        for (int i = 0; i < 20 && (q16.size() + q4.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_pops16", 32'(pops16), 4);
        chk("ovf_pops4", 32'(pops4), 4);
        chk("ovf_empty", 32'(iv_valid), 0);
        do_clear();

        // Saturation: pulses 20 apart, 4-bit instance clamps at 15
        iv_ready = 1'b1;
        pv = '0; pv[2] = 1'b1; pv[22] = 1'b1; pv[42] = 1'b1;
        ev = '1;
        push_both(20, 15);
        push_both(20, 15);
        play(50);
        chk("sat_drain", 32'(q16.size() + q4.size()), 0);
        chk("sat_flag_s", 32'(s_sat), 1);
        chk("sat_flag", 32'(sat), 0);
        chk("sat_max_s", 32'(s_max_iv), st(15));
        chk("sat_max", 32'(max_iv), st(20));
        chk("sat_drop", 32'(drop), 0);
        do_clear();

        // Clear coinciding with an edge while intervals are queued
        iv_ready = 1'b0;
        pv = '0; pv[2] = 1'b1; pv[7] = 1'b1; pv[12] = 1'b1;
        ev = '1;
        play(14);
        chk("clr_queued", 32'(iv_valid), 1);
        pulse_in = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        pulse_in = 1'b0;
        chk("clr_valid", 32'(iv_valid), 0);
        chk("clr_count", 32'(pulse_count), 0);
        chk("clr_min", 32'(min_iv), st(32'hFFFF));
        chk("clr_max", 32'(max_iv), 0);
        iv_ready = 1'b1;
        pv = '0; pv[5] = 1'b1; pv[11] = 1'b1;
        push_both(6, 6);
        play(16);
        chk("clr_drain", 32'(q16.size() + q4.size()), 0);
        chk("clr_count2", 32'(pulse_count), st(2));
        chk("clr_min2", 32'(min_iv), st(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
